// File: rtl/fp_round_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fp_round_pkg
// Purpose  : Shared types and helpers for the mantissa rounding pipeline.
//            rnd_mode_t  - IEEE-754 rounding mode encoding
//            round_inc() - decides whether the kept mantissa is incremented,
//                          given the mode, the operand sign, and the L/G/S bits
// Revision : 1.0 - initial release
// ============================================================================
package fp_round_pkg;

    typedef enum logic [1:0] {
        RNE = 2'b00,    // round to nearest, ties to even
        RTZ = 2'b01,    // round toward zero (truncate)
        RDN = 2'b10,    // round toward -infinity
        RUP = 2'b11     // round toward +infinity
    } rnd_mode_t;

    // The mantissa is a magnitude, so the directed modes only increment it
    // when rounding moves the value away from zero: RDN for negatives,
    // RUP for positives.
    function automatic logic round_inc(
        input rnd_mode_t mode,
        input logic      sign,
        input logic      lsb,
        input logic      guard,
        input logic      sticky
    );
        logic inc;
        inc = 1'b0;
        case (mode)
            RNE:     inc = guard & (sticky | lsb);
            RTZ:     inc = 1'b0;
            RDN:     inc = sign & (guard | sticky);
            RUP:     inc = ~sign & (guard | sticky);
            default: inc = 1'b0;
        endcase
        return inc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp_round_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : fp_round_pipe_if
// Purpose  : Operand/result handshake bundle for fp_round_pipe.
//            Upstream side : i_valid, o_ready, i_man, i_sign, i_rnd_mode
//            Downstream    : o_valid, i_ready, o_man_result, o_ov_flow,
//                            o_inexact
//            Signal names are given from the rounding stage's point of view.
//            slave  - modport used by the rounding stage
//            master - modport used by the surrounding logic (source + sink)
// Revision : 1.0 - initial release
// ============================================================================
interface fp_round_pipe_if #(
    parameter int SIZE_MAN        = 28,
    parameter int SIZE_MAN_RESULT = 24
) ();

    logic                       i_valid;
    logic                       o_ready;
    logic [SIZE_MAN-1:0]        i_man;
    logic                       i_sign;
    logic [1:0]                 i_rnd_mode;

    logic                       o_valid;
    logic                       i_ready;
    logic [SIZE_MAN_RESULT-1:0] o_man_result;
    logic                       o_ov_flow;
    logic                       o_inexact;

    modport slave (
        input  i_valid, i_man, i_sign, i_rnd_mode, i_ready,
        output o_ready, o_valid, o_man_result, o_ov_flow, o_inexact
    );

    modport master (
        output i_valid, i_man, i_sign, i_rnd_mode, i_ready,
        input  o_ready, o_valid, o_man_result, o_ov_flow, o_inexact
    );

endinterface
`default_nettype wire

// File: rtl/round_incr.sv
`default_nettype none
// ============================================================================
// Module   : round_incr
// Purpose  : WIDTH-bit incrementer: o_sum/o_cout = i_a + i_cin.
//            i_a    in  WIDTH  operand
//            i_cin  in  1      increment request
//            o_sum  out WIDTH  low WIDTH bits of the sum
//            o_cout out 1      carry out of the MSB
// Revision : 1.0 - initial release
// ============================================================================
module round_incr #(
    parameter int WIDTH = 24
) (
    input  wire logic [WIDTH-1:0] i_a,
    input  wire logic             i_cin,
    output logic      [WIDTH-1:0] o_sum,
    output logic                  o_cout
);

    assign {o_cout, o_sum} = {1'b0, i_a} + {{WIDTH{1'b0}}, i_cin};

endmodule
`default_nettype wire

// File: rtl/fp_round_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fp_round_pipe
// Purpose  : Two-stage pipelined mantissa rounder with valid/ready flow
//            control. Rounds a SIZE_MAN-bit MSB-aligned mantissa down to
//            SIZE_MAN_RESULT bits under RNE/RTZ/RDN/RUP and flags carry-out
//            and inexact.
//            i_clk  in  1  clock
//            i_rst  in  1  synchronous active-high reset
//            bus    slave modport of fp_round_pipe_if (operand in, result out)
//            Requires SIZE_MAN - SIZE_MAN_RESULT >= 2 (guard + sticky).
// Revision : 1.0 - initial release
// ============================================================================
module fp_round_pipe
    import fp_round_pkg::*;
#(
    parameter int SIZE_MAN        = 28,
    parameter int SIZE_MAN_RESULT = 24
) (
    input  wire logic       i_clk,
    input  wire logic       i_rst,
    fp_round_pipe_if.slave  bus
);

    localparam int c_DROP_W = SIZE_MAN - SIZE_MAN_RESULT;

    // ------------------------------------------------------------------
    // Field split and rounding decision (ahead of S1)
    // ------------------------------------------------------------------
    logic [SIZE_MAN_RESULT-1:0] w_kept;
    logic                       w_guard;
    logic                       w_sticky;
    logic                       w_inc;
    logic                       w_inexact;

    assign w_kept    = bus.i_man[SIZE_MAN-1 -: SIZE_MAN_RESULT];
    assign w_guard   = bus.i_man[c_DROP_W-1];
    assign w_sticky  = |bus.i_man[c_DROP_W-2:0];
    assign w_inexact = w_guard | w_sticky;
    assign w_inc     = round_inc(rnd_mode_t'(bus.i_rnd_mode), bus.i_sign,
                                 w_kept[0], w_guard, w_sticky);

    // ------------------------------------------------------------------
    // Flow control: a stage may load when it is empty or when its
    // current contents leave in the same cycle.
    // ------------------------------------------------------------------
    logic r_s1_valid;
    logic r_s2_valid;
    logic w_s1_ready;
    logic w_s2_ready;

    assign w_s2_ready  = ~r_s2_valid | bus.i_ready;
    assign w_s1_ready  = ~r_s1_valid | w_s2_ready;
    assign bus.o_ready = w_s1_ready;

    // ------------------------------------------------------------------
    // Stage 1: kept bits, increment decision, inexact
    // ------------------------------------------------------------------
    logic [SIZE_MAN_RESULT-1:0] r_s1_kept;
    logic                       r_s1_inc;
    logic                       r_s1_inexact;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1_valid   <= 1'b0;
            r_s1_kept    <= '0;
            r_s1_inc     <= 1'b0;
            r_s1_inexact <= 1'b0;
        end else if (w_s1_ready) begin
            r_s1_valid <= bus.i_valid;
            if (bus.i_valid) begin
                r_s1_kept    <= w_kept;
                r_s1_inc     <= w_inc;
                r_s1_inexact <= w_inexact;
            end
        end
    end

    // ------------------------------------------------------------------
    // Incrementer between S1 and S2
    // ------------------------------------------------------------------
    logic [SIZE_MAN_RESULT-1:0] w_sum;
    logic                       w_cout;
    logic [SIZE_MAN_RESULT-1:0] w_man_rounded;

    round_incr #(
        .WIDTH (SIZE_MAN_RESULT)
    ) u_round_incr (
        .i_a    (r_s1_kept),
        .i_cin  (r_s1_inc),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    // A carry-out only happens from an all-ones mantissa, so the sum shifted
    // right by one is always 1000...0; the exponent bump is done downstream.
    assign w_man_rounded = w_cout ? {1'b1, {(SIZE_MAN_RESULT-1){1'b0}}} : w_sum;

    // ------------------------------------------------------------------
    // Stage 2: rounded mantissa and flags (drives the outputs directly)
    // ------------------------------------------------------------------
    logic [SIZE_MAN_RESULT-1:0] r_s2_man;
    logic                       r_s2_ov;
    logic                       r_s2_inexact;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s2_valid   <= 1'b0;
            r_s2_man     <= '0;
            r_s2_ov      <= 1'b0;
            r_s2_inexact <= 1'b0;
        end else if (w_s2_ready) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_man     <= w_man_rounded;
                r_s2_ov      <= w_cout;
                r_s2_inexact <= r_s1_inexact;
            end
        end
    end

    assign bus.o_valid      = r_s2_valid;
    assign bus.o_man_result = r_s2_man;
    assign bus.o_ov_flow    = r_s2_ov;
    assign bus.o_inexact    = r_s2_inexact;

endmodule
`default_nettype wire

// File: tb/tb_fp_round_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_round_pipe
// Purpose  : Self-checking bench for fp_round_pipe. Three instances
//            (28/24, 56/53, 26/24) share one stimulus stream; each has its
//            own expected-result queue filled from an arithmetic rounding
//            model at every accepted operand and drained at every emitted
//            result. Directed checks cover the worked rounding examples,
//            latency, back-pressure and mid-stream reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_round_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic        rdy;
    logic        sign;
    logic [1:0]  mode;
    logic [63:0] man;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fp_round_pipe_if #(.SIZE_MAN(28), .SIZE_MAN_RESULT(24)) bus0 ();
    fp_round_pipe_if #(.SIZE_MAN(56), .SIZE_MAN_RESULT(53)) bus1 ();
    fp_round_pipe_if #(.SIZE_MAN(26), .SIZE_MAN_RESULT(24)) bus2 ();

    assign bus0.i_valid = valid;  assign bus0.i_ready = rdy;  assign bus0.i_sign = sign;
    assign bus0.i_rnd_mode = mode; assign bus0.i_man = man[27:0];
    assign bus1.i_valid = valid;  assign bus1.i_ready = rdy;  assign bus1.i_sign = sign;
    assign bus1.i_rnd_mode = mode; assign bus1.i_man = man[55:0];
    assign bus2.i_valid = valid;  assign bus2.i_ready = rdy;  assign bus2.i_sign = sign;
    assign bus2.i_rnd_mode = mode; assign bus2.i_man = man[25:0];

    fp_round_pipe #(.SIZE_MAN(28), .SIZE_MAN_RESULT(24)) u_dut0 (.i_clk(clk), .i_rst(rst), .bus(bus0));
    fp_round_pipe #(.SIZE_MAN(56), .SIZE_MAN_RESULT(53)) u_dut1 (.i_clk(clk), .i_rst(rst), .bus(bus1));
    fp_round_pipe #(.SIZE_MAN(26), .SIZE_MAN_RESULT(24)) u_dut2 (.i_clk(clk), .i_rst(rst), .bus(bus2));

    task automatic check_eq(input string tag, input logic [65:0] act, input logic [65:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    // Reference: round the value numerically by comparing the discarded
    // remainder against one half ULP. Result packed as {ov, inexact, man64}.
    function automatic logic [65:0] ref_round(input logic [63:0] m_in, input int sm, input int sr,
                                              input logic [1:0] md, input logic sg);
        logic [63:0] m, kept, rem, half, sum, one;
        logic        inc, inx, ov;
        int          d;
        d    = sm - sr;
        one  = 64'd1;
        m    = (sm >= 64) ? m_in : (m_in & ((one << sm) - 1));
        kept = m >> d;
        rem  = m & ((one << d) - 1);
        half = one << (d - 1);
        inx  = (rem != 0);
        case (md)
            2'd0:    inc = (rem > half) || ((rem == half) && kept[0]);
            2'd1:    inc = 1'b0;
            2'd2:    inc = sg && inx;
            default: inc = !sg && inx;
        endcase
        sum = kept + {63'd0, inc};
        ov  = (sum == (one << sr));
        if (ov) sum = one << (sr - 1);
        return {ov, inx, sum};
    endfunction

    // ------------------------------------------------------------------
    // Scoreboard: queues of expected results per instance
    // ------------------------------------------------------------------
    logic [65:0] q0[$];
    logic [65:0] q1[$];
    logic [65:0] q2[$];

    always @(negedge clk) begin
        if (rst) begin
            q0.delete(); q1.delete(); q2.delete();
        end else begin
            if (bus0.o_valid && rdy) begin
                if (q0.size() == 0) check_eq("sb0_extra", {65'd0, bus0.o_valid}, 66'd0);
                else check_eq("sb0", {bus0.o_ov_flow, bus0.o_inexact, 64'(bus0.o_man_result)}, q0.pop_front());
            end
            if (bus1.o_valid && rdy) begin
                if (q1.size() == 0) check_eq("sb1_extra", {65'd0, bus1.o_valid}, 66'd0);
                else check_eq("sb1", {bus1.o_ov_flow, bus1.o_inexact, 64'(bus1.o_man_result)}, q1.pop_front());
            end
            if (bus2.o_valid && rdy) begin
                if (q2.size() == 0) check_eq("sb2_extra", {65'd0, bus2.o_valid}, 66'd0);
                else check_eq("sb2", {bus2.o_ov_flow, bus2.o_inexact, 64'(bus2.o_man_result)}, q2.pop_front());
            end
            if (valid && bus0.o_ready) q0.push_back(ref_round(man, 28, 24, mode, sign));
            if (valid && bus1.o_ready) q1.push_back(ref_round(man, 56, 53, mode, sign));
            if (valid && bus2.o_ready) q2.push_back(ref_round(man, 26, 24, mode, sign));
        end
    end

    // One operand into an empty pipe with i_ready high; checks latency and
    // the 28/24 result against the given constants. The accept edge counts
    // as the first of the two register edges.
    task automatic send_one(input string tag, input logic [27:0] m, input logic [1:0] md,
                            input logic sg, input logic [23:0] er, input logic eo, input logic ei);
        int lat;
        @(posedge clk); #1;
        valid = 1'b1; man = {36'd0, m}; mode = md; sign = sg; rdy = 1'b1;
        @(negedge clk);
        check_eq({tag, "_rdy"}, {65'd0, bus0.o_ready}, 66'd1);
        @(posedge clk); #1;
        valid = 1'b0;
        lat = 1;
        while (!bus0.o_valid && lat < 6) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq({tag, "_lat"}, 66'(lat), 66'd2);
        check_eq({tag, "_res"}, 66'(bus0.o_man_result), 66'(er));
        check_eq({tag, "_ov"},  {65'd0, bus0.o_ov_flow}, {65'd0, eo});
        check_eq({tag, "_inx"}, {65'd0, bus0.o_inexact}, {65'd0, ei});
    endtask

    logic [63:0] bp_man[6];
    logic [1:0]  bp_mode[6];
    logic        bp_sign[6];

    initial begin
        logic [23:0] held;
        logic        acc;
        int          k;

        rst = 1'b1; valid = 1'b0; rdy = 1'b1; man = '0; mode = 2'd0; sign = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_valid", {65'd0, bus0.o_valid}, 66'd0);
        check_eq("rst_man",   66'(bus0.o_man_result), 66'd0);
        check_eq("rst_flags", {64'd0, bus0.o_ov_flow, bus0.o_inexact}, 66'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_eq("rst_ready", {65'd0, bus0.o_ready}, 66'd1);

        // Worked rounding examples on the 28/24 instance
        send_one("rne_up",   28'h0000018, 2'd0, 1'b0, 24'h000002, 1'b0, 1'b1);
        send_one("rne_tie",  28'h0000008, 2'd0, 1'b0, 24'h000000, 1'b0, 1'b1);
        send_one("rne_ovf",  28'hFFFFFF8, 2'd0, 1'b0, 24'h800000, 1'b1, 1'b1);
        send_one("rtz_ovf",  28'hFFFFFF8, 2'd1, 1'b0, 24'hFFFFFF, 1'b0, 1'b1);
        send_one("rup_neg",  28'h0000011, 2'd3, 1'b1, 24'h000001, 1'b0, 1'b1);
        send_one("rdn_neg",  28'h0000011, 2'd2, 1'b1, 24'h000002, 1'b0, 1'b1);
        send_one("rup_pos",  28'h0000011, 2'd3, 1'b0, 24'h000002, 1'b0, 1'b1);
        send_one("rdn_pos",  28'h0000011, 2'd2, 1'b0, 24'h000001, 1'b0, 1'b1);
        for (int md = 0; md < 4; md++)
            send_one("exact", 28'h0000010, 2'(md), 1'($urandom_range(0, 1)), 24'h000001, 1'b0, 1'b0);

        // Back-pressure: 6 operands, i_ready low for the first 6 cycles
        for (int i = 0; i < 6; i++) begin
            bp_man[i]  = {$urandom, $urandom};
            bp_mode[i] = 2'($urandom_range(0, 3));
            bp_sign[i] = 1'($urandom_range(0, 1));
        end
        k = 0;
        held = '0;
        for (int cyc = 0; cyc < 14; cyc++) begin
            @(posedge clk); #1;
            rdy   = (cyc >= 6);
            valid = (k < 6);
            if (k < 6) begin
                man = bp_man[k]; mode = bp_mode[k]; sign = bp_sign[k];
            end
            @(negedge clk);
            acc = valid && bus0.o_ready;
            if (cyc < 2) check_eq("bp_accept", {65'd0, bus0.o_ready}, 66'd1);
            if (cyc == 2) held = bus0.o_man_result;
            if (cyc >= 2 && cyc < 6) begin
                check_eq("bp_ready", {65'd0, bus0.o_ready}, 66'd0);
                check_eq("bp_valid", {65'd0, bus0.o_valid}, 66'd1);
                check_eq("bp_hold",  66'(bus0.o_man_result), 66'(held));
            end
            if (cyc >= 6 && cyc < 12) check_eq("bp_thru", {65'd0, bus0.o_valid}, 66'd1);
            if (cyc == 12) check_eq("bp_drained", {65'd0, bus0.o_valid}, 66'd0);
            if (acc) k++;
        end

        // Reset with two operands in flight
        @(posedge clk); #1;
        rdy = 1'b0; valid = 1'b1; man = {$urandom, $urandom}; mode = 2'd0;
        @(posedge clk); #1;
        man = {$urandom, $urandom};
        @(posedge clk); #1;
        valid = 1'b0;
        @(negedge clk);
        check_eq("mid_full", {64'd0, bus0.o_valid, bus0.o_ready}, 66'b10);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        check_eq("mid_valid", {65'd0, bus0.o_valid}, 66'd0);
        check_eq("mid_man",   66'(bus0.o_man_result), 66'd0);
        check_eq("mid_flags", {64'd0, bus0.o_ov_flow, bus0.o_inexact}, 66'd0);
        rst = 1'b0; rdy = 1'b1;
        @(negedge clk);
        check_eq("mid_ready", {65'd0, bus0.o_ready}, 66'd1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_eq("mid_gone", {63'd0, bus0.o_valid, bus1.o_valid, bus2.o_valid}, 66'd0);

        // Random traffic across all three instances and all modes
        for (int i = 0; i < 500; i++) begin
            @(posedge clk); #1;
            valid = ($urandom_range(0, 9) < 7);
            rdy   = ($urandom_range(0, 9) < 7);
            man   = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0:       man = man | ~64'h7;          // all-ones kept field
                1:       man = man & ~64'h7;          // low dropped bits clear
                default: ;
            endcase
            mode = 2'($urandom_range(0, 3));
            sign = 1'($urandom_range(0, 1));
        end
        @(posedge clk); #1;
        valid = 1'b0; rdy = 1'b1;
        k = 0;
        while ((q0.size() + q1.size() + q2.size()) != 0 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check_eq("drain", 66'(q0.size() + q1.size() + q2.size()), 66'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
